// File: rtl/csa_acc_pkg.sv
// csa_acc_pkg: shared state encoding and default widths for the carry-save stream accumulator.
package csa_acc_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_e;
  localparam int DEF_N       = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_COUNT_W = 16;
endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: W-bit 3:2 compressor row; carry is pre-shifted left by one and truncated.
module csa_3to2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W-1:0] maj;
  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;
endmodule

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: streaming accumulator holding the running total in sum/carry form.
// Optional operand counter and out_count port enabled by CSA_ACC_COUNT_EN.
module csa_stream_accumulator
  import csa_acc_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int ACC_W = DEF_ACC_W
`ifdef CSA_ACC_COUNT_EN
  , parameter int COUNT_W = DEF_COUNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
`ifdef CSA_ACC_COUNT_EN
  , output logic [COUNT_W-1:0] out_count
`endif
);
  state_e           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [ACC_W-1:0] x, csa_s, csa_c;
  logic             acc;

  assign x = {{(ACC_W-N){1'b0}}, in_data};

  csa_3to2 #(.W(ACC_W)) u_csa (
    .a(s_q), .b(c_q), .c(x), .sum(csa_s), .carry(csa_c)
  );

  always_comb begin
    acc     = in_valid && (state_q == ACCUM);
    state_d = (state_q == ACCUM)   ? ((acc && in_last) ? RESOLVE : ACCUM) :
              (state_q == RESOLVE) ? OUTPUT :
              (out_ready ? ACCUM : OUTPUT);
    s_d     = (state_q == RESOLVE) ? '0 : acc ? csa_s : s_q;
    c_d     = (state_q == RESOLVE) ? '0 : acc ? csa_c : c_q;
    sum_d   = (state_q == RESOLVE) ? s_q + c_q : sum_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign out_sum   = sum_q;

`ifdef CSA_ACC_COUNT_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d;
  always_comb begin
    cnt_d       = (state_q == RESOLVE) ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
    out_count_d = (state_q == RESOLVE) ? cnt_q : out_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      out_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_count_q <= out_count_d;
    end
  end
  assign out_count = out_count_q;
`endif
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: scoreboard bench for csa_stream_accumulator (N=8, ACC_W=16).
module tb_csa_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
`ifdef CSA_ACC_COUNT_EN
  logic [15:0] out_count;
`endif

  typedef struct {
    logic [15:0] sum;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_sum = '0;
  logic [15:0] m_cnt = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  csa_stream_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef CSA_ACC_COUNT_EN
    , .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Result handshake happens at the next rising edge; compare against the oldest pushed group.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", {16'h0, out_sum}, {16'h0, e.sum});
`ifdef CSA_ACC_COUNT_EN
        chk("count", {16'h0, out_count}, {16'h0, e.cnt});
`endif
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_sum = m_sum + {8'h0, d};
    m_cnt = m_cnt + 16'd1;
    if (last) begin
      sb.push_back('{sum: m_sum, cnt: m_cnt});
      m_sum = '0;
      m_cnt = '0;
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'd1);
    chk({tag, "_out_sum"}, {16'h0, out_sum}, 32'd0);
`ifdef CSA_ACC_COUNT_EN
    chk({tag, "_out_count"}, {16'h0, out_count}, 32'd0);
`endif
  endtask

  initial begin
    #23;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    chk("lat_resolve_valid", {31'h0, out_valid}, 32'd0);
    chk("lat_resolve_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("lat_output_valid", {31'h0, out_valid}, 32'd1);
    drain("drain_basic");

    send(8'hA5, 1'b1);
    drain("drain_single");

    for (int i = 0; i < 256; i++) send(8'hFF, i == 255);
    drain("drain_wrap256");
    for (int i = 0; i < 258; i++) send(8'hFF, i == 257);
    drain("drain_wrap258");

    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, out_valid}, 32'd1);
      chk("bp_sum", {16'h0, out_sum}, 32'h0033);
      chk("bp_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("drain_bp");
    send(8'h07, 1'b1);
    drain("drain_after_bp");

    send(8'h10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(8'h20, 1'b0);
    @(posedge clk); #1;
    send(8'h30, 1'b1);
    drain("drain_bubbles");

    send(8'h40, 1'b0);
    send(8'h40, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    m_sum = '0;
    m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h10, 1'b1);
    drain("drain_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
